uart_tx_path: RTL and testbench
===============================

Name: uart_tx_path

Overview:
Buffered UART transmit path: CPU-side byte writes go into a synchronous TX FIFO, and a serializer frames and shifts the bytes out on uart_tx. It is the transmit-direction counterpart of the existing RX capture path and is instantiated beside it inside the UART peripheral. It runs entirely on the system clock, with an internal baud-rate clock enable and no derived clocks.

Parameters:
DEPTH, 8, TX FIFO entries; must be a power of 2, minimum 2
ADDR_W, 3, log2(DEPTH)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
tx_wr_en  input  1  push tx_wr_data into the FIFO this cycle
tx_wr_data  input  8  byte to transmit
baud_div  input  16  bit period minus 1, in clk cycles
parity_mode  input  2  0 none, 1 even, 2 odd, 3 treated as none
stop_bit  input  2  0 one stop bit; 1, 2 or 3 two stop bits
tx_enable  input  1  allow new frames to start
uart_tx  output  1  serial line, idle high
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at the end of each frame
tx_full  output  1  FIFO full
tx_empty  output  1  FIFO empty
tx_level  output  ADDR_W+1  FIFO occupancy
tx_overflow  output  1  one-cycle pulse when a write arrives while full

Behaviour:
- One clock domain: clk. Reset: asynchronous assert on rst_n low, synchronous deassert.
- Reset values: uart_tx=1, tx_busy=0, tx_done=0, tx_full=0, tx_empty=1, tx_level=0, tx_overflow=0. The FIFO is flushed and the FSM goes to IDLE.
- FIFO write: when tx_wr_en=1 and tx_full=0, the byte is stored. tx_full, tx_empty and tx_level are registered and update on the next cycle.
- Write while full: data is dropped and tx_overflow pulses. Fullness is judged on the pre-cycle value, so a write in the same cycle as a pop while full is still dropped.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START: when tx_enable=1 and tx_empty=0. That cycle the head byte is popped, loaded into the shift register, and baud_div, parity_mode and stop_bit are latched for the whole frame. Mid-frame input changes are ignored.
- uart_tx is registered. The start bit (0) appears the cycle after the pop.
- Bit timer: each bit lasts baud_div+1 cycles. baud_div=0 gives 1 cycle per bit.
- START: 1 bit period, then DATA.
- DATA: 8 bits, LSB first; a counter runs 0..7. Then PARITY if the parity mode is 1 or 2, else STOP.
- PARITY: even mode sends XOR of the 8 data bits; odd mode sends its inverse. 1 bit period.
- STOP: line held high for 1 or 2 bit periods.
- At the last STOP cycle the FSM returns to IDLE and tx_done pulses for one cycle, coinciding with the first IDLE cycle.
- Back-to-back frames: IDLE lasts at least one cycle (line high) before the next START.
- tx_busy = (state != IDLE).
- tx_enable deasserted mid-frame: the current frame completes and no new frame starts.
- Reset mid-frame: line returns high immediately, the frame is aborted and no tx_done is issued.
- Frame length in cycles: (baud_div+1) * (1 + 8 + P + S), where P is 1 with parity (else 0) and S is the stop-bit count.

Decomposition:
- Shared include uart_defs.v holds:
  - parity codes: UART_PAR_NONE/EVEN/ODD
  - stop codes: UART_STOP_1/2
  - FSM state encodings
  - so uart_top, uart_rx and this block share them.
- One sub-module: uart_sync_fifo. It is a single-clock FIFO with parameters DEPTH and width 8, providing full, empty and level. Pointers are ADDR_W+1 bits, with wrap detected from the MSB.
- The serializer FSM and bit timer live in uart_tx_path itself.

Test Plan:
- Basic frame: baud_div=3, parity 0, stop 0, write 0x55, tx_enable=1.
  - uart_tx shows low×4, then 1,0,1,0,1,0,1,0 with each bit 4 cycles, then high×4.
  - tx_done pulses exactly 40 cycles after the start bit begins.
- Parity: even mode with 0x07 gives parity bit 1; odd mode with 0x00 gives parity bit 1.
  - With stop 1, each frame is 12 bit periods long.
- FIFO boundary (DEPTH=4), tx_enable=0: write 0xA1..0xA5.
  - tx_full asserts after the 4th write; the 5th write pulses tx_overflow and tx_level stays 4.
  - Enabling then sends exactly A1, A2, A3, A4 in order, each separated by 1 idle cycle.
  - tx_empty=1 afterwards.
- Config stability: start a frame with baud_div=1, then change it to 7 during DATA.
  - The frame finishes at 2 cycles per bit; the next frame uses 8 cycles per bit.
- Enable and reset mid-frame:
  - Drop tx_enable during DATA with 2 bytes queued: one frame completes and the second stays queued (tx_level=1).
  - Assert rst_n=0 during DATA: uart_tx goes to 1 asynchronously, tx_level=0, and no tx_done is issued.

Source files
------------

// File: rtl/uart_tx_path_pkg.sv
// uart_tx_path_pkg: shared parity/stop codes, serializer state encoding and parity helpers
package uart_tx_path_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;
    localparam logic [1:0] STOP_1   = 2'd0;

    function automatic logic has_parity(input logic [1:0] mode);
        return mode == PAR_EVEN || mode == PAR_ODD;
    endfunction

    function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] mode);
        return ^d ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock byte FIFO with full/empty/level and a registered overflow pulse
module uart_sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);

    logic [7:0]      mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            push;
    logic            pop;

    always_comb begin
        push    = wr_en && !full;
        pop     = rd_en && !empty;
        level   = wr_ptr - rd_ptr;
        empty   = wr_ptr == rd_ptr;
        // pointers one lap apart: same slot, differing wrap bit
        full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
        rd_data = mem[rd_ptr[ADDR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr   <= pop ? rd_ptr + 1'b1 : rd_ptr;
            overflow <= wr_en && full;
        end
    end

endmodule

// File: rtl/uart_tx_path.sv
// uart_tx_path: buffered UART transmitter, TX FIFO feeding a framing serializer with baud timer
module uart_tx_path
    import uart_tx_path_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_wr_en,
    input  logic [7:0]        tx_wr_data,
    input  logic [15:0]       baud_div,
    input  logic [1:0]        parity_mode,
    input  logic [1:0]        stop_bit,
    input  logic              tx_enable,
    output logic              uart_tx,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx_full,
    output logic              tx_empty,
    output logic [ADDR_W:0]   tx_level,
    output logic              tx_overflow
);

    tx_state_e   state;
    logic [7:0]  head;
    logic [7:0]  shift;
    logic [15:0] div_q;
    logic [15:0] timer;
    logic [2:0]  bit_idx;
    logic [1:0]  par_q;
    logic        par_q_bit;
    logic        two_stop;
    logic        stop_idx;
    logic        pop;
    logic        bit_end;

    always_comb begin
        pop     = state == IDLE && tx_enable && !tx_empty;
        bit_end = timer == div_q;
        tx_busy = state != IDLE;
    end

    uart_sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (tx_wr_en),
        .wr_data  (tx_wr_data),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (tx_full),
        .empty    (tx_empty),
        .level    (tx_level),
        .overflow (tx_overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            uart_tx   <= 1'b1;
            tx_done   <= 1'b0;
            shift     <= '0;
            div_q     <= '0;
            timer     <= '0;
            bit_idx   <= '0;
            par_q     <= PAR_NONE;
            par_q_bit <= 1'b0;
            two_stop  <= 1'b0;
            stop_idx  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            timer   <= (state == IDLE || bit_end) ? '0 : timer + 16'd1;
            case (state)
                IDLE: begin
                    uart_tx <= !pop;
                    if (pop) begin
                        // frame configuration is frozen here for the whole frame
                        state     <= START;
                        shift     <= head;
                        div_q     <= baud_div;
                        par_q     <= parity_mode;
                        par_q_bit <= parity_bit(head, parity_mode);
                        two_stop  <= stop_bit != STOP_1;
                    end
                end
                START: if (bit_end) begin
                    state   <= DATA;
                    uart_tx <= shift[0];
                    bit_idx <= '0;
                end
                DATA: if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state    <= has_parity(par_q) ? PARITY : STOP;
                        uart_tx  <= has_parity(par_q) ? par_q_bit : 1'b1;
                        stop_idx <= 1'b0;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        uart_tx <= shift[bit_idx + 3'd1];
                    end
                end
                PARITY: if (bit_end) begin
                    state    <= STOP;
                    uart_tx  <= 1'b1;
                    stop_idx <= 1'b0;
                end
                STOP: if (bit_end) begin
                    if (two_stop && !stop_idx) stop_idx <= 1'b1;
                    else begin
                        state   <= IDLE;
                        tx_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_path.sv
// tb_uart_tx_path: directed and randomized frame checks against a bit-list model of UART framing
module tb_uart_tx_path;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_wr_en = 1'b0;
    logic [7:0]  tx_wr_data = '0;
    logic [15:0] baud_div = '0;
    logic [1:0]  parity_mode = '0;
    logic [1:0]  stop_bit = '0;
    logic        tx_enable = 1'b0;
    logic        uart_tx, tx_busy, tx_done, tx_full, tx_empty, tx_overflow;
    logic [2:0]  tx_level;

    int checks = 0;
    int errors = 0;

    uart_tx_path #(.DEPTH(4), .ADDR_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_wr_en    (tx_wr_en),
        .tx_wr_data  (tx_wr_data),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop_bit    (stop_bit),
        .tx_enable   (tx_enable),
        .uart_tx     (uart_tx),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_full     (tx_full),
        .tx_empty    (tx_empty),
        .tx_level    (tx_level),
        .tx_overflow (tx_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        tx_wr_en   = 1'b1;
        tx_wr_data = d;
        tick();
        tx_wr_en   = 1'b0;
    endtask

    task automatic wait_start(input int limit, output int w);
        w = 0;
        while (uart_tx !== 1'b0 && w < limit) begin
            tick();
            w++;
        end
        if (uart_tx !== 1'b0) chk("start_timeout", uart_tx, 0);
    endtask

    // Expected line: start 0, data LSB first, optional parity, 1 or 2 stop bits, each held div+1 cycles
    task automatic frame_body(input logic [7:0] d, input int div, input int par, input int stp);
        bit q[$];
        int ones;
        bit first = 1;
        ones = $countones(d);
        q.push_back(0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (par == 1) q.push_back(ones % 2);
        if (par == 2) q.push_back(1 - ones % 2);
        q.push_back(1);
        if (stp != 0) q.push_back(1);
        foreach (q[i]) begin
            for (int r = 0; r <= div; r++) begin
                if (!first) tick();
                first = 0;
                chk($sformatf("bit%0d_d%02h", i, d), uart_tx, q[i]);
            end
        end
        chk("done_early", tx_done, 0);
        tick();
        chk("done_pulse", tx_done, 1);
        chk("busy_end", tx_busy, 0);
        chk("line_idle", uart_tx, 1);
    endtask

    task automatic frame_check(input logic [7:0] d, input int div, input int par, input int stp,
                               input int limit, output int w);
        wait_start(limit, w);
        frame_body(d, div, par, stp);
    endtask

    initial begin
        int w;
        int cnt;
        logic [7:0] rb;
        int rd, rp, rs;

        #12;
        chk("rst_tx", uart_tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_full", tx_full, 0);
        chk("rst_empty", tx_empty, 1);
        chk("rst_level", tx_level, 0);
        chk("rst_ovf", tx_overflow, 0);
        tick();
        rst_n = 1'b1;
        tick();

        baud_div = 3; parity_mode = 0; stop_bit = 0; tx_enable = 1'b1;
        write_byte(8'h55);
        frame_check(8'h55, 3, 0, 0, 20, w);
        chk("basic_empty", tx_empty, 1);

        parity_mode = 1; stop_bit = 1;
        write_byte(8'h07);
        frame_check(8'h07, 3, 1, 1, 20, w);
        parity_mode = 2;
        write_byte(8'h00);
        frame_check(8'h00, 3, 2, 1, 20, w);

        for (int k = 0; k < 8; k++) begin
            rb = 8'($urandom);
            rd = $urandom_range(0, 3);
            rp = $urandom_range(0, 3);
            rs = $urandom_range(0, 3);
            baud_div = 16'(rd); parity_mode = 2'(rp); stop_bit = 2'(rs);
            write_byte(rb);
            frame_check(rb, rd, rp, rs, 20, w);
        end

        tx_enable = 1'b0; baud_div = 0; parity_mode = 1; stop_bit = 0;
        write_byte(8'hA1);
        write_byte(8'hA2);
        write_byte(8'hA3);
        chk("fifo_not_full3", tx_full, 0);
        write_byte(8'hA4);
        chk("fifo_full4", tx_full, 1);
        chk("fifo_level4", tx_level, 4);
        write_byte(8'hA5);
        chk("fifo_ovf", tx_overflow, 1);
        chk("fifo_level_ovf", tx_level, 4);
        tick();
        chk("fifo_ovf_clear", tx_overflow, 0);
        tx_enable = 1'b1;
        frame_check(8'hA1, 0, 1, 0, 20, w);
        for (int k = 2; k <= 4; k++) begin
            frame_check(8'(8'hA0 + k), 0, 1, 0, 20, w);
            chk("fifo_gap", w, 1);
        end
        tick();
        chk("fifo_drained", tx_empty, 1);
        chk("fifo_level0", tx_level, 0);
        chk("fifo_no_a5", uart_tx, 1);

        tx_enable = 1'b0; baud_div = 1; parity_mode = 0; stop_bit = 0;
        write_byte(8'h3C);
        write_byte(8'hC3);
        tx_enable = 1'b1;
        wait_start(20, w);
        fork
            frame_body(8'h3C, 1, 0, 0);
            begin
                repeat (5) @(posedge clk);
                #1 baud_div = 7;
            end
        join
        frame_check(8'hC3, 7, 0, 0, 20, w);
        chk("cfg_gap", w, 1);

        tx_enable = 1'b0; baud_div = 1;
        write_byte(8'h11);
        write_byte(8'h22);
        tx_enable = 1'b1;
        wait_start(20, w);
        fork
            frame_body(8'h11, 1, 0, 0);
            begin
                repeat (5) @(posedge clk);
                #1 tx_enable = 1'b0;
            end
        join
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (uart_tx !== 1'b1) cnt++;
        end
        chk("en_no_start", cnt, 0);
        chk("en_level1", tx_level, 1);
        chk("en_busy0", tx_busy, 0);

        tx_enable = 1'b1;
        wait_start(20, w);
        repeat (6) tick();
        chk("rstmid_low_before", tx_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_tx", uart_tx, 1);
        chk("rstmid_level", tx_level, 0);
        chk("rstmid_empty", tx_empty, 1);
        chk("rstmid_busy", tx_busy, 0);
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (tx_done !== 1'b0 || uart_tx !== 1'b1) cnt++;
        end
        chk("rstmid_no_done", cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
